// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer for the MIPS multi-cycle core.
// Executes mult/multu/div/divu using a radix-2 shift-add / restoring-subtract
// datapath over WIDTH cycles. The results go into the architectural HI/LO registers.
// Optional feature macro: MULDIV_ABORT_EN adds the abort port. When abort is high
// during RUN or FIX, the operation is cancelled without writing a result.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             divz,
    output logic             badop,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_div;     // 1: div/divu, 0: mult/multu
    logic               sign_a;     // sign of a (always 0 for the unsigned ops)
    logic               sign_b;
    logic               b_zero;
    logic [WIDTH-1:0]   a_cap;      // raw dividend, returned in hi on divide-by-zero
    logic [WIDTH-1:0]   opnd;       // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // {upper, multiplier} or {rem, quo}

    // Decode of the launch request.
    logic             funct_ok;
    logic             start_div;
    logic             start_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign funct_ok     = (funct[5:2] == 4'b0110);
    assign start_div    = funct[1];
    assign start_signed = ~funct[0];
    assign mag_a        = (start_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b        = (start_signed && b[WIDTH-1]) ? -b : b;

    // A cancel request is only honoured while an operation is in flight.
    logic kill;
`ifdef MULDIV_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    // One radix-2 iteration of the multiply and the divide datapaths.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_part;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    // Compute the next accumulator value for the current iteration.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so a missed branch can never infer a latch.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0])
            mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_diff = {1'b0, div_part} - {2'b00, opnd};
        if (!div_diff[WIDTH+1])
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Apply the sign correction and the divide-by-zero override for the FIX write-back.
    logic               neg;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        neg  = sign_a ^ sign_b;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_div) begin
            if (b_zero) begin
                res_hi = a_cap;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
    end

    // Sequencer FSM with registered outputs; reset is synchronous and has top priority.
    always_ff @(posedge clk) begin
        // NOTE: all state updates here use non-blocking assignments, so every register samples pre-edge values.
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            a_cap  <= '0;
            opnd   <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            divz   <= 1'b0;
            badop  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done  <= 1'b0;
            badop <= 1'b0;
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (funct_ok) begin
                                op_div <= start_div;
                                sign_a <= start_signed & a[WIDTH-1];
                                sign_b <= start_signed & b[WIDTH-1];
                                b_zero <= (b == '0);
                                a_cap  <= a;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= RUN;
                                if (start_div) begin
                                    opnd <= mag_b;
                                    acc  <= {{WIDTH{1'b0}}, mag_a};
                                end else begin
                                    opnd <= mag_a;
                                    acc  <= {{WIDTH{1'b0}}, mag_b};
                                end
                            end else begin
                                badop <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        acc <= op_div ? div_next : mul_next;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    FIX: begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        divz  <= op_div & b_zero;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
